// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the iterative execute-stage ALU:
//   - opcode encodings OP_ADD .. OP_MFLO (4-bit op_sel values)
//   - handshake FSM state encoding used by iter_alu
//   - multiply/divide latency (accept to out_valid), DATA_WIDTH + 1 cycles
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_NOR   = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  // Handshake FSM: IDLE accepts, MUL/DIV iterate, DONE pulses out_valid.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Cycles from accept of a MULT/MULTU/DIV/DIVU to its out_valid pulse.
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int MULDIV_LATENCY     = DEFAULT_DATA_WIDTH + 1;

  function automatic int muldiv_latency(input int dataWidth);
    return dataWidth + 1;
  endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// ---------------------------------------------------------------------------
// iter_muldiv_core
// Radix-2 iterative multiplier (shift-add) and restoring divider working on
// operand magnitudes, one bit per cycle for DATA_WIDTH cycles, with the sign
// fix applied on the way out.
// Ports:
//   clk, rst    clock, synchronous active-high reset (aborts any operation)
//   start       load operands and begin (only pulsed while idle)
//   is_div      1 = divide, 0 = multiply
//   is_signed   treat a/b as two's complement
//   a, b        multiplicand/multiplier or dividend/divisor
//   done        high in the final iteration cycle; hi_out/lo_out/dbz valid
//   hi_out      product high half or remainder
//   lo_out      product low half or quotient
//   dbz         divide with a zero divisor
// ---------------------------------------------------------------------------
module iter_muldiv_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_div,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  dbz
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic                    r_busy;
  logic                    r_div;
  logic                    r_negQ;
  logic                    r_negR;
  logic                    r_dbz;
  logic [DATA_WIDTH-1:0]   r_dividend;
  logic [DATA_WIDTH-1:0]   r_magB;
  logic [2*DATA_WIDTH-1:0] r_prod;
  logic [DATA_WIDTH-1:0]   r_rem;
  logic [DATA_WIDTH-1:0]   r_quo;
  logic [CW-1:0]           r_count;

  logic                    w_aNeg;
  logic                    w_bNeg;
  logic [DATA_WIDTH-1:0]   w_magA;
  logic [DATA_WIDTH-1:0]   w_magBIn;
  logic [DATA_WIDTH:0]     w_sum;
  logic [2*DATA_WIDTH-1:0] w_prodNext;
  logic [2*DATA_WIDTH-1:0] w_prodFix;
  logic [DATA_WIDTH:0]     w_shift;
  logic                    w_ge;
  logic [DATA_WIDTH-1:0]   w_diff;
  logic [DATA_WIDTH-1:0]   w_remNext;
  logic [DATA_WIDTH-1:0]   w_quoNext;
  logic [DATA_WIDTH-1:0]   w_quoFix;
  logic [DATA_WIDTH-1:0]   w_remFix;

  // Magnitudes of the incoming operands; the most negative value maps onto
  // itself, which is the correct unsigned magnitude 2^(DATA_WIDTH-1).
  always_comb begin
    w_aNeg   = is_signed & a[DATA_WIDTH-1];
    w_bNeg   = is_signed & b[DATA_WIDTH-1];
    w_magA   = w_aNeg ? -a : a;
    w_magBIn = w_bNeg ? -b : b;
  end

  // One iteration of each algorithm. The multiplier adds the multiplicand
  // into the top half when the current multiplier bit is set and shifts the
  // whole register right. The divider shifts the next dividend bit into the
  // partial remainder and subtracts the divisor whenever it fits; because
  // the restored remainder is always below the divisor, the subtraction
  // result fits in DATA_WIDTH bits.
  always_comb begin
    w_sum      = {1'b0, r_prod[2*DATA_WIDTH-1:DATA_WIDTH]}
               + (r_prod[0] ? {1'b0, r_magB} : '0);
    w_prodNext = {w_sum, r_prod[DATA_WIDTH-1:1]};
    w_shift    = {r_rem, r_quo[DATA_WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_magB});
    w_diff     = w_shift[DATA_WIDTH-1:0] - r_magB;
    w_remNext  = w_ge ? w_diff : w_shift[DATA_WIDTH-1:0];
    w_quoNext  = {r_quo[DATA_WIDTH-2:0], w_ge};
  end

  // Results are taken straight from the final iteration's next values so the
  // top can capture them on the same edge that retires the last bit.
  always_comb begin
    w_prodFix = r_negQ ? -w_prodNext : w_prodNext;
    w_quoFix  = r_negQ ? -w_quoNext : w_quoNext;
    w_remFix  = r_negR ? -w_remNext : w_remNext;
    done      = r_busy && (r_count == '0);
    dbz       = r_dbz;
    if (!r_div) begin
      hi_out = w_prodFix[2*DATA_WIDTH-1:DATA_WIDTH];
      lo_out = w_prodFix[DATA_WIDTH-1:0];
    end else if (r_dbz) begin
      hi_out = r_dividend;
      lo_out = '1;
    end else begin
      hi_out = w_remFix;
      lo_out = w_quoFix;
    end
  end

  // Operand capture on start, then one bit per cycle until the counter
  // reaches zero. Reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_div      <= 1'b0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_dbz      <= 1'b0;
      r_dividend <= '0;
      r_magB     <= '0;
      r_prod     <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_count    <= '0;
    end else if (start) begin
      r_busy     <= 1'b1;
      r_div      <= is_div;
      r_negQ     <= w_aNeg ^ w_bNeg;
      r_negR     <= w_aNeg;
      r_dbz      <= is_div && (b == '0);
      r_dividend <= a;
      r_magB     <= w_magBIn;
      r_prod     <= {{DATA_WIDTH{1'b0}}, w_magA};
      r_rem      <= '0;
      r_quo      <= w_magA;
      r_count    <= CW'(DATA_WIDTH - 1);
    end else if (r_busy) begin
      if (r_div) begin
        r_rem <= w_remNext;
        r_quo <= w_quoNext;
      end else begin
        r_prod <= w_prodNext;
      end
      r_count <= r_count - 1'b1;
      if (r_count == '0) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iter_alu.sv
// ---------------------------------------------------------------------------
// iter_alu
// Registered execute-stage ALU with single-cycle ops, iterative
// multiply/divide, HI/LO registers and a valid/ready handshake.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     operands/opcode present; accepted when in_ready is high
//   in_ready     high only in IDLE; the hazard unit stalls on it
//   op_sel       opcode (see alu_pkg)
//   operand1/2   A (rs) and B (rt)
//   shamt        shift amount for SLL/SRL/SRA
//   out_valid    one-cycle pulse; result/zero/div_by_zero valid
//   result       registered result (lo for mul/div)
//   zero         registered result == 0
//   div_by_zero  registered divide-by-zero flag
//   hi, lo       HI/LO registers, written only on mul/div completion
// ---------------------------------------------------------------------------
module iter_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_WIDTH-1:0]   op_sel,
  input  logic [DATA_WIDTH-1:0]  operand1,
  input  logic [DATA_WIDTH-1:0]  operand2,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   div_by_zero,
  output logic [DATA_WIDTH-1:0]  hi,
  output logic [DATA_WIDTH-1:0]  lo
);

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_dbz;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;

  logic                  w_accept;
  logic                  w_isMul;
  logic                  w_isDiv;
  logic                  w_isSigned;
  logic [DATA_WIDTH-1:0] w_aluRes;
  logic                  w_mdDone;
  logic                  w_mdDbz;
  logic [DATA_WIDTH-1:0] w_mdHi;
  logic [DATA_WIDTH-1:0] w_mdLo;

  // Opcode classification for the multi-cycle path.
  always_comb begin
    w_isMul    = (op_sel == OP_MULT) || (op_sel == OP_MULTU);
    w_isDiv    = (op_sel == OP_DIV)  || (op_sel == OP_DIVU);
    w_isSigned = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    w_accept   = in_valid && in_ready;
  end

  // Single-cycle datapath. Shifts take their amount from shamt only;
  // MFHI/MFLO read the HI/LO registers as they stand.
  always_comb begin
    w_aluRes = '0;
    case (op_sel)
      OP_ADD:  w_aluRes = operand1 + operand2;
      OP_SUB:  w_aluRes = operand1 - operand2;
      OP_AND:  w_aluRes = operand1 & operand2;
      OP_OR:   w_aluRes = operand1 | operand2;
      OP_SLT:  w_aluRes = {{(DATA_WIDTH-1){1'b0}},
                           ($signed(operand1) < $signed(operand2))};
      OP_XOR:  w_aluRes = operand1 ^ operand2;
      OP_NOR:  w_aluRes = ~(operand1 | operand2);
      OP_SLL:  w_aluRes = operand1 << shamt;
      OP_SRL:  w_aluRes = operand1 >> shamt;
      OP_SRA:  w_aluRes = $signed(operand1) >>> shamt;
      OP_MFHI: w_aluRes = r_hi;
      OP_MFLO: w_aluRes = r_lo;
      default: w_aluRes = '0;
    endcase
  end

  iter_muldiv_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (w_accept && (w_isMul || w_isDiv)),
    .is_div    (w_isDiv),
    .is_signed (w_isSigned),
    .a         (operand1),
    .b         (operand2),
    .done      (w_mdDone),
    .hi_out    (w_mdHi),
    .lo_out    (w_mdLo),
    .dbz       (w_mdDbz)
  );

  // State register for the handshake FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and handshake outputs. Only IDLE is ready; DONE lasts exactly
  // one cycle so out_valid is a single pulse.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_isMul)      w_nextState = ST_MUL;
          else if (w_isDiv) w_nextState = ST_DIV;
          else              w_nextState = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_mdDone) w_nextState = ST_DONE;
      end
      ST_DONE: begin
        out_valid   = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Result registers. Single-cycle ops load on accept; mul/div load together
  // with HI/LO on the edge that leaves MUL/DIV. Everything holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (w_accept && !(w_isMul || w_isDiv)) begin
      r_result <= w_aluRes;
      r_zero   <= (w_aluRes == '0);
      r_dbz    <= 1'b0;
    end else if (((r_state == ST_MUL) || (r_state == ST_DIV)) && w_mdDone) begin
      r_result <= w_mdLo;
      r_zero   <= (w_mdLo == '0);
      r_dbz    <= w_mdDbz;
      r_hi     <= w_mdHi;
      r_lo     <= w_mdLo;
    end
  end

  assign result      = r_result;
  assign zero        = r_zero;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_iter_alu.sv
// ---------------------------------------------------------------------------
// tb_iter_alu
// Self-checking bench for iter_alu (DATA_WIDTH = 32). A behavioural model
// tracks expected handshake and register values from plain arithmetic; one
// compare process checks it against the DUT every cycle. Directed cases pin
// the model with hand-computed values, then randomized traffic runs.
// ---------------------------------------------------------------------------
module tb_iter_alu;
  import alu_pkg::*;

  localparam int MD_LATENCY = 33;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic        muldiv;
  } ref_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [4:0]  shamt;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;
  int pulseCount = 0;
  bit checkEnable = 1'b0;

  // Model state: values the DUT must show during the current cycle.
  logic        mReady;
  logic        mValid;
  logic [31:0] mResult;
  logic        mZero;
  logic        mDbz;
  logic [31:0] mHi;
  logic [31:0] mLo;
  int          mLeft;
  ref_t        pend;

  iter_alu #(
    .DATA_WIDTH(32),
    .SEL_WIDTH(4),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_sel      (op_sel),
    .operand1    (operand1),
    .operand2    (operand2),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .result      (result),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the opcode definitions.
  function automatic ref_t refOp(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh,
                                 input logic [31:0] curHi, input logic [31:0] curLo);
    ref_t r;
    logic [63:0] p;
    longint sp;
    r.res = '0; r.hi = curHi; r.lo = curLo; r.dbz = 1'b0; r.muldiv = 1'b0;
    p = '0;
    case (op)
      4'd0:  r.res = a + b;
      4'd1:  r.res = a - b;
      4'd2:  r.res = a & b;
      4'd3:  r.res = a | b;
      4'd4:  r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  r.res = a ^ b;
      4'd6:  r.res = ~(a | b);
      4'd7:  r.res = a << sh;
      4'd8:  r.res = a >> sh;
      4'd9:  r.res = $signed(a) >>> sh;
      4'd10: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        p = sp;
        r.hi = p[63:32]; r.lo = p[31:0]; r.muldiv = 1'b1;
      end
      4'd11: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32]; r.lo = p[31:0]; r.muldiv = 1'b1;
      end
      4'd12: begin
        r.muldiv = 1'b1;
        if (b == 32'd0) begin
          r.lo = 32'hFFFF_FFFF; r.hi = a; r.dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000; r.hi = 32'd0;
        end else begin
          r.lo = $signed(a) / $signed(b);
          r.hi = $signed(a) % $signed(b);
        end
      end
      4'd13: begin
        r.muldiv = 1'b1;
        if (b == 32'd0) begin
          r.lo = 32'hFFFF_FFFF; r.hi = a; r.dbz = 1'b1;
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
      4'd14: r.res = curHi;
      default: r.res = curLo;
    endcase
    if (r.muldiv) r.res = r.lo;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  always @(posedge clk) cycleCount = cycleCount + 1;

  always @(negedge clk) if (out_valid === 1'b1) pulseCount = pulseCount + 1;

  // Behavioural model: counts the busy period of mul/div, ignores requests
  // while busy, and exposes results for exactly one cycle of out_valid.
  always @(posedge clk) begin
    ref_t r;
    if (rst) begin
      mReady = 1'b1; mValid = 1'b0; mResult = '0; mZero = 1'b1;
      mDbz = 1'b0; mHi = '0; mLo = '0; mLeft = 0;
    end else if (mValid) begin
      mValid = 1'b0;
      mReady = 1'b1;
    end else if (!mReady) begin
      mLeft = mLeft - 1;
      if (mLeft == 0) begin
        mValid = 1'b1; mResult = pend.res; mZero = (pend.res == 32'd0);
        mDbz = pend.dbz; mHi = pend.hi; mLo = pend.lo;
      end
    end else if (in_valid) begin
      r = refOp(op_sel, operand1, operand2, shamt, mHi, mLo);
      mReady = 1'b0;
      if (r.muldiv) begin
        pend = r;
        mLeft = MD_LATENCY - 1;
      end else begin
        mValid = 1'b1; mResult = r.res; mZero = (r.res == 32'd0); mDbz = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("model_in_ready", 64'(in_ready), 64'(mReady));
      checkOutput("model_out_valid", 64'(out_valid), 64'(mValid));
      checkOutput("model_result", 64'(result), 64'(mResult));
      checkOutput("model_zero", 64'(zero), 64'(mZero));
      checkOutput("model_dbz", 64'(div_by_zero), 64'(mDbz));
      checkOutput("model_hi", 64'(hi), 64'(mHi));
      checkOutput("model_lo", 64'(lo), 64'(mLo));
    end
  end

  // Issue one operation from IDLE and wait (bounded) for its out_valid;
  // optional noise toggles in_valid and operands while the DUT is busy.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh,
                               input bit noise, output int latency);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) checkOutput("ready_timeout", 64'(in_ready), 64'd1);
    op_sel = op; operand1 = a; operand2 = b; shamt = sh; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    latency = 1;
    while (out_valid !== 1'b1 && latency < 100) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        op_sel = 4'($urandom);
        operand1 = $urandom;
        operand2 = $urandom;
      end
      @(negedge clk);
      latency++;
    end
    in_valid = 1'b0;
    if (out_valid !== 1'b1) checkOutput("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int acc[3];
    logic [3:0] b2bOps[3];
    bit took;
    int guard;

    rst = 1'b1; in_valid = 1'b0; op_sel = '0;
    operand1 = '0; operand2 = '0; shamt = '0;
    repeat (3) @(negedge clk);
    checkEnable = 1'b1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_zero", 64'(zero), 64'd1);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(OP_ADD, 32'd5, 32'd7, 5'd0, 1'b0, lat);
    checkOutput("add_latency", 64'(lat), 64'd1);
    checkOutput("add_result", 64'(result), 64'd12);
    checkOutput("add_zero", 64'(zero), 64'd0);
    applyStimulus(OP_SUB, 32'd7, 32'd7, 5'd0, 1'b0, lat);
    checkOutput("sub_result", 64'(result), 64'd0);
    checkOutput("sub_zero", 64'(zero), 64'd1);
    applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, lat);
    checkOutput("slt_result", 64'(result), 64'd1);
    applyStimulus(OP_SRA, 32'h8000_0000, 32'h1234_5678, 5'd4, 1'b0, lat);
    checkOutput("sra_result", 64'(result), 64'hF800_0000);
    applyStimulus(OP_SRL, 32'h8000_0000, 32'h1234_5678, 5'd4, 1'b0, lat);
    checkOutput("srl_result", 64'(result), 64'h0800_0000);

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd4, 5'd0, 1'b1, lat);
    checkOutput("mult_latency", 64'(lat), 64'(MD_LATENCY));
    checkOutput("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mult_lo", 64'(lo), 64'hFFFF_FFF4);
    applyStimulus(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0, lat);
    checkOutput("mfhi_result", 64'(result), 64'hFFFF_FFFF);

    applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd0, 1'b0, lat);
    checkOutput("divu_lo", 64'(lo), 64'd14);
    checkOutput("divu_hi", 64'(hi), 64'd2);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0, lat);
    checkOutput("div_lo", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("div_hi", 64'(hi), 64'hFFFF_FFFF);
    applyStimulus(OP_DIV, 32'd5, 32'd0, 5'd0, 1'b0, lat);
    checkOutput("dbz_latency", 64'(lat), 64'(MD_LATENCY));
    checkOutput("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
    checkOutput("dbz_hi", 64'(hi), 64'd5);
    checkOutput("dbz_flag", 64'(div_by_zero), 64'd1);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0, lat);
    checkOutput("minneg1_lo", 64'(lo), 64'h8000_0000);
    checkOutput("minneg1_hi", 64'(hi), 64'd0);
    checkOutput("minneg1_dbz", 64'(div_by_zero), 64'd0);

    // Reset in the middle of a DIVU: no completion, registers cleared.
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    op_sel = OP_DIVU; operand1 = 32'd1000; operand2 = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    pulseCount = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_hi", 64'(hi), 64'd0);
    checkOutput("midrst_lo", 64'(lo), 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("midrst_no_pulse", 64'(pulseCount), 64'd0);
    applyStimulus(OP_ADD, 32'd40, 32'd2, 5'd0, 1'b0, lat);
    checkOutput("postrst_add", 64'(result), 64'd42);

    // Back-to-back with in_valid held: ADD, MULTU, ADD.
    @(negedge clk);
    pulseCount = 0;
    b2bOps[0] = OP_ADD; b2bOps[1] = OP_MULTU; b2bOps[2] = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      op_sel = b2bOps[i];
      operand1 = (i == 1) ? 32'hFFFF_FFFF : 32'd10 * (i + 1);
      operand2 = (i == 1) ? 32'd2 : 32'd20;
      in_valid = 1'b1;
      guard = 0;
      do begin
        took = (in_ready === 1'b1);
        @(negedge clk);
        guard++;
      end while (!took && guard < 100);
      acc[i] = cycleCount;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("b2b_gap1", 64'(acc[1] - acc[0]), 64'd2);
    checkOutput("b2b_gap2", 64'(acc[2] - acc[1]), 64'd34);
    checkOutput("b2b_pulses", 64'(pulseCount), 64'd3);
    checkOutput("b2b_result", 64'(result), 64'd50);
    checkOutput("b2b_hi", 64'(hi), 64'd1);
    checkOutput("b2b_lo", 64'(lo), 64'hFFFF_FFFE);

    // Randomized traffic; the model compare process does the checking.
    for (int n = 0; n < 4000; n++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      op_sel = 4'($urandom);
      operand1 = randOperand();
      operand2 = randOperand();
      shamt = 5'($urandom);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, registered ALU for the execute stage. Successor to the combinational ALU.
- Keeps the existing single-cycle operation set and adds arithmetic shift right.
- Adds iterative multiply and divide (signed and unsigned) with HI/LO result registers, plus a valid/ready handshake so the pipeline can stall on long operations.
- Sits between ID/EX operand muxing and the EX/MEM register; the hazard unit consumes in_ready as the stall source.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >= 8.
- SEL_WIDTH, 4, opcode width; fixed at 4.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and opcode present this cycle.
- in_ready  output  1  block can accept; high only in IDLE.
- op_sel  input  SEL_WIDTH  operation code.
- operand1  input  DATA_WIDTH  A / rs.
- operand2  input  DATA_WIDTH  B / rt.
- shamt  input  SHAMT_WIDTH  shift amount.
- out_valid  output  1  one-cycle pulse; result, zero and div_by_zero valid.
- result  output  DATA_WIDTH  registered result.
- zero  output  1  registered; result == 0.
- div_by_zero  output  1  registered; high with out_valid on a DIV/DIVU whose divisor is 0.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, SLT=4 (signed), XOR=5, NOR=6, SLL=7, SRL=8 (logical), SRA=9, MULT=10, MULTU=11, DIV=12, DIVU=13, MFHI=14, MFLO=15.
- Handshake: accept occurs when in_valid && in_ready. Inputs are ignored when in_ready is low; there is no queuing.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on accept of a single-cycle op (0-9, 14, 15), register result/zero and go to DONE. Latency is 1: out_valid in cycle T+1.
  - IDLE: on accept of MULT/MULTU, go to MUL; on DIV/DIVU, go to DIV. Load the iteration counter with DATA_WIDTH-1.
  - MUL: radix-2 shift-add on operand magnitudes, one bit per cycle. After DATA_WIDTH cycles, apply the sign fix for MULT and go to DONE. out_valid in cycle T+DATA_WIDTH+1.
  - DIV: restoring division on magnitudes, one quotient bit per cycle, same latency as MUL.
    - Signed DIV: quotient sign = XOR of operand signs; remainder sign = dividend sign.
  - DONE: out_valid=1 for exactly one cycle, then IDLE. in_ready is low in MUL, DIV and DONE.
- HI/LO results:
  - MULT/MULTU: {hi,lo} = full 2*DATA_WIDTH product; result = lo.
  - DIV/DIVU: lo = quotient, hi = remainder; result = lo.
  - HI/LO are written only in the DONE transition of mul/div. They hold otherwise, including across single-cycle ops.
  - MFHI/MFLO return the current hi/lo. They are single-cycle ops.
- Divide boundaries:
  - Divisor 0: lo = all ones, hi = dividend, div_by_zero = 1. Latency is unchanged.
  - Signed MIN / -1: lo = MIN, hi = 0, div_by_zero = 0.
- Shifts use shamt only; operand2 is ignored. shamt >= DATA_WIDTH cannot occur by width.
- All arithmetic wraps modulo 2^DATA_WIDTH. No overflow trap.
- result, zero and div_by_zero hold their values between out_valid pulses.
- Reset (any state, including mid-MUL/DIV): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, div_by_zero=0, hi=0, lo=0. The in-flight operation is discarded with no out_valid.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_MFLO);
  - FSM state encoding;
  - the MULDIV latency constant (DATA_WIDTH+1).
- One sub-module, iter_muldiv_core:
  - owns the counter, partial product/remainder shift registers and sign handling;
  - interface: start, is_div, is_signed, a, b -> done, hi_out, lo_out, dbz.
- iter_alu keeps the handshake FSM, the single-cycle datapath and the HI/LO/result registers.

Test Plan:
- Reset, then ADD 5+7 -> out_valid at T+1, result=12, zero=0. SUB 7-7 -> result=0, zero=1.
- SLT 0xFFFFFFFF vs 1 -> result=1. SRA 0x80000000 shamt=4 -> 0xF8000000. SRL same -> 0x08000000.
- MULT -3 × 4 (DATA_WIDTH=32) -> in_ready low 33 cycles; out_valid at T+33; hi=0xFFFFFFFF, lo=0xFFFFFFF4. in_valid pulses during busy are ignored; a following MFHI returns 0xFFFFFFFF.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=-3, hi=-1. DIV 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- rst asserted at cycle 10 of a DIVU -> next cycle in_ready=1, hi=lo=0, no out_valid. A new ADD completes normally.
- Back-to-back ADD, MULTU, ADD with in_valid held high -> accepts at T, T+2, T+2+34. Exactly three out_valid pulses with correct results.
